gecko_run_supervisor: RTL and testbench
=======================================

Name: gecko_run_supervisor

Overview:
- Synthesizable supervisor sequencer for a gecko_micro core. It replaces the hand-written reset, run, dump and patch loop previously written directly in benches.
- Per run: holds the core in reset, waits for finished/faulted (with timeout), reads back a result window over the supervisor memory port, then writes a mailbox word carrying the previous run's last result.
- Repeats for NUM_RUNS runs, generalising the fixed two-reset sequence.
- Sits between a top-level controller and the core's supervisor_request/supervisor_response ports.

Parameters:
- ADDR_WIDTH, 32, supervisor address width
- DATA_WIDTH, 32, supervisor data width (multiple of 8)
- NUM_RUNS, 3, run count; must be >= 1
- RESET_CYCLES, 20, core reset hold per run; must be >= 1
- TIMEOUT_CYCLES, 65536, max RUN wait before fault; 0 disables the timeout
- DUMP_BASE, 'h0, first dump address
- DUMP_WORDS, 4, words read per run; must be >= 1
- MAILBOX_ADDR, 'h0, mailbox write address
- MAX_OUTSTANDING, 2, maximum in-flight dump reads; must be >= 1

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  level; sampled in IDLE
- core_rst  out  1  active-high reset to the core
- finished_flag  in  1  from core
- faulted_flag  in  1  from core
- req_valid  out  1  supervisor request valid
- req_ready  in  1  supervisor request ready
- req_read_enable  out  1  request is a read
- req_write_enable  out  DATA_WIDTH/8  byte write enables
- req_addr  out  ADDR_WIDTH  request address
- req_data  out  DATA_WIDTH  request write data
- req_id  out  1  0 = dump read, 1 = mailbox write
- resp_valid  in  1  supervisor response valid
- resp_ready  out  1  supervisor response ready
- resp_data  in  DATA_WIDTH  response data
- resp_id  in  1  echoed request id
- dump_valid  out  1  dump stream valid
- dump_ready  in  1  dump stream ready
- dump_data  out  DATA_WIDTH  dumped word
- dump_last  out  1  final word of the run
- dump_fault  out  1  run ended faulted or timed out
- run_index  out  $clog2(NUM_RUNS+1)  current run number
- busy  out  1  state != IDLE/DONE
- done  out  1  all runs complete (sticky until reset)

Behaviour:
- Reset (rst=0, asynchronous) values:
  - state = IDLE, core_rst = 1.
  - All valid outputs, busy and done = 0.
  - run_index = 0; outstanding, issue and return counters = 0; last_word = 0.
- IDLE: start=1 moves to HOLD on the next edge.
- HOLD:
  - core_rst = 1 for exactly RESET_CYCLES cycles.
  - Then core_rst deasserts and the FSM enters RUN.
  - core_rst is a registered output.
- RUN:
  - Timer counts each cycle.
  - finished_flag or faulted_flag goes to DUMP. The cause is latched: fault_lat = faulted_flag at exit.
  - Timer reaching TIMEOUT_CYCLES goes to DUMP with fault_lat = 1.
  - If both flags are set in the same cycle, fault_lat = 1.
- DUMP:
  - Issues DUMP_WORDS reads: read_enable = 1, write_enable = 0, id = 0, addr = DUMP_BASE + 4*i, i = 0..DUMP_WORDS-1.
  - The address adder wraps modulo 2^ADDR_WIDTH.
  - A request is offered only while outstanding < MAX_OUTSTANDING.
  - req_valid holds with stable payload until req_ready (std handshake; no valid-depends-on-ready).
  - Outstanding counter: +1 on request fire, -1 on id=0 response fire. If both fire in the same cycle, the counter is unchanged.
  - resp_ready = dump_ready for id=0 responses, so responses flow through combinationally.
  - dump_valid = resp_valid & (resp_id == 0).
  - dump_last = 1 on returned word DUMP_WORDS-1.
  - dump_fault = fault_lat on every word of the run.
  - Each returned word is stored as last_word.
  - After the last word is accepted, go to PATCH.
- PATCH:
  - One write: addr = MAILBOX_ADDR, data = last_word of the previous run (0 for run 0), write_enable = all ones, read_enable = 0, id = 1.
  - After the write fires, wait for the id=1 response. resp_ready = 1 for id=1; it is never forwarded to the dump stream.
  - Then run_index increments. If run_index == NUM_RUNS go to DONE (done = 1, core_rst = 1), else go to HOLD.
- DONE: terminal state; only reset leaves it.
- start is ignored outside IDLE.
- Reset mid-operation: all state clears immediately and in-flight responses are forgotten. The surrounding system must reset the memory slave together with this block.
- Response with an unexpected id in the current state: resp_ready = 1 and the response is dropped. The sticky internal protocol error bit is exposed only as an assertion.

Decomposition:
- gecko package gains:
  - gecko_supervisor_state_t enum: IDLE, HOLD, RUN, DUMP, PATCH, DONE.
  - Constants GECKO_SUP_ID_DUMP = 0 and GECKO_SUP_ID_PATCH = 1.
- One sub-module, gecko_credit_counter (parametrised up/down counter with full/empty), tracks outstanding reads.
- Top level is a flattened-port wrapper suitable for adaptation onto std_mem_intf.

Test Plan:
- Default params, core model asserts finished 50 cycles after core_rst deasserts, always-ready slave:
  - core_rst low exactly 20 cycles after each HOLD entry.
  - Dump reads at 0x0, 0x4, 0x8, 0xC; dump_last on the 4th word.
  - Mailbox writes 0, then run0 word3, then run1 word3.
  - done = 1 after 3 runs.
- Slave with 5-cycle read latency, MAX_OUTSTANDING=2: never more than 2 id=0 requests in flight; word order preserved.
- dump_ready toggling 1/0 each cycle: no word lost or duplicated; req_valid payload stable while req_ready=0.
- TIMEOUT_CYCLES=100, core never finishes: DUMP entered 100 cycles into RUN; dump_fault = 1 on all 4 words.
- finished_flag and faulted_flag both high in the same cycle: dump_fault = 1.
- rst pulled low during DUMP with 1 read outstanding: outputs return to reset values asynchronously; new start after release gives a clean run 0 with mailbox data 0.

Source files
------------

// File: rtl/gecko_run_supervisor_pkg.sv
// Shared types and constants for the gecko_micro run supervisor.
// Holds the sequencer state encoding and the supervisor request ids.
package gecko_run_supervisor_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        RUN,
        DUMP,
        PATCH,
        DONE
    } gecko_supervisor_state_t;

    localparam logic GECKO_SUP_ID_DUMP  = 1'b0;
    localparam logic GECKO_SUP_ID_PATCH = 1'b1;

    // Width of a counter that must be able to hold max_val itself.
    function automatic int unsigned gecko_cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/gecko_credit_counter.sv
// Up/down occupancy counter with full/empty flags; one-cycle registered update.
// Simultaneous increment and decrement leave the count unchanged.
module gecko_credit_counter #(
    parameter int unsigned MAX_COUNT = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_inc,
    input  logic                           i_dec,
    output logic [$clog2(MAX_COUNT+1)-1:0] o_count,
    output logic                           o_full,
    output logic                           o_empty
);

    localparam int unsigned CW = $clog2(MAX_COUNT + 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_inc && !i_dec) begin
            r_count <= r_count + 1'b1;
        end else if (i_dec && !i_inc) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_full  = (r_count == CW'(MAX_COUNT));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/gecko_run_supervisor.sv
// Reset/run/dump/patch sequencer for a gecko_micro core over its supervisor port.
// Dump responses pass combinationally to the dump stream; dump_ready backpressures the slave.
module gecko_run_supervisor
    import gecko_run_supervisor_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH      = 32,
    parameter int unsigned           DATA_WIDTH      = 32,
    parameter int unsigned           NUM_RUNS        = 3,
    parameter int unsigned           RESET_CYCLES    = 20,
    parameter int unsigned           TIMEOUT_CYCLES  = 65536,
    parameter logic [ADDR_WIDTH-1:0] DUMP_BASE       = '0,
    parameter int unsigned           DUMP_WORDS      = 4,
    parameter logic [ADDR_WIDTH-1:0] MAILBOX_ADDR    = '0,
    parameter int unsigned           MAX_OUTSTANDING = 2,
    localparam int unsigned          RUN_W           = $clog2(NUM_RUNS + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    core_rst,
    input  logic                    finished_flag,
    input  logic                    faulted_flag,
    output logic                    req_valid,
    input  logic                    req_ready,
    output logic                    req_read_enable,
    output logic [DATA_WIDTH/8-1:0] req_write_enable,
    output logic [ADDR_WIDTH-1:0]   req_addr,
    output logic [DATA_WIDTH-1:0]   req_data,
    output logic                    req_id,
    input  logic                    resp_valid,
    output logic                    resp_ready,
    input  logic [DATA_WIDTH-1:0]   resp_data,
    input  logic                    resp_id,
    output logic                    dump_valid,
    input  logic                    dump_ready,
    output logic [DATA_WIDTH-1:0]   dump_data,
    output logic                    dump_last,
    output logic                    dump_fault,
    output logic [RUN_W-1:0]        run_index,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned HOLD_W = gecko_cnt_width(RESET_CYCLES);
    localparam int unsigned WORD_W = gecko_cnt_width(DUMP_WORDS);
    localparam int unsigned OUT_W  = $clog2(MAX_OUTSTANDING + 1);

    gecko_supervisor_state_t r_state, w_next_state;

    logic                  r_core_rst;
    logic [HOLD_W-1:0]     r_hold_cnt;
    logic [31:0]           r_timer;
    logic                  r_fault_lat;
    logic [WORD_W-1:0]     r_issue_cnt;
    logic [WORD_W-1:0]     r_ret_cnt;
    logic [DATA_WIDTH-1:0] r_last_word;
    logic [DATA_WIDTH-1:0] r_mbox_dat;
    logic                  r_patch_sent;
    logic [RUN_W-1:0]      r_run_index;
    logic                  r_proto_err;

    logic             w_full, w_empty;
    logic [OUT_W-1:0] w_outstanding;
    logic             w_timeout, w_last_ret, w_resp_expected;
    logic             w_req_fire, w_resp_fire, w_dump_fire;

    assign w_timeout   = (TIMEOUT_CYCLES != 0) && (r_timer == 32'(TIMEOUT_CYCLES - 1));
    assign w_last_ret  = (r_ret_cnt == WORD_W'(DUMP_WORDS - 1));
    assign w_req_fire  = req_valid && req_ready;
    assign w_resp_fire = resp_valid && resp_ready;
    assign w_dump_fire = dump_valid && dump_ready;

    always_comb begin
        w_next_state     = r_state;
        req_valid        = 1'b0;
        req_read_enable  = 1'b0;
        req_write_enable = '0;
        req_addr         = '0;
        req_data         = '0;
        req_id           = GECKO_SUP_ID_DUMP;
        resp_ready       = 1'b1;
        dump_valid       = 1'b0;
        w_resp_expected  = 1'b0;
        case (r_state)
            IDLE: if (start) w_next_state = HOLD;
            HOLD: if (r_hold_cnt == HOLD_W'(RESET_CYCLES - 1)) w_next_state = RUN;
            RUN:  if (finished_flag || faulted_flag || w_timeout) w_next_state = DUMP;
            DUMP: begin
                // Gating on credit only: valid can never drop without a fire.
                req_valid       = (r_issue_cnt != WORD_W'(DUMP_WORDS)) && !w_full;
                req_read_enable = 1'b1;
                req_addr        = DUMP_BASE + ADDR_WIDTH'({r_issue_cnt, 2'b00});
                if (resp_id == GECKO_SUP_ID_DUMP && !w_empty) begin
                    w_resp_expected = 1'b1;
                    resp_ready      = dump_ready;
                    dump_valid      = resp_valid;
                    if (resp_valid && dump_ready && w_last_ret) w_next_state = PATCH;
                end
            end
            PATCH: begin
                req_valid        = !r_patch_sent;
                req_write_enable = '1;
                req_addr         = MAILBOX_ADDR;
                req_data         = r_mbox_dat;
                req_id           = GECKO_SUP_ID_PATCH;
                if (r_patch_sent && resp_id == GECKO_SUP_ID_PATCH) begin
                    w_resp_expected = 1'b1;
                    if (resp_valid)
                        w_next_state = (r_run_index == RUN_W'(NUM_RUNS - 1)) ? DONE : HOLD;
                end
            end
            DONE:    w_next_state = DONE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_core_rst   <= 1'b1;
            r_hold_cnt   <= '0;
            r_timer      <= '0;
            r_fault_lat  <= 1'b0;
            r_issue_cnt  <= '0;
            r_ret_cnt    <= '0;
            r_last_word  <= '0;
            r_mbox_dat   <= '0;
            r_patch_sent <= 1'b0;
            r_run_index  <= '0;
            r_proto_err  <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_core_rst <= (w_next_state == IDLE) || (w_next_state == HOLD) || (w_next_state == DONE);
            r_hold_cnt <= (r_state == HOLD) ? r_hold_cnt + 1'b1 : '0;
            r_timer    <= (r_state == RUN) ? r_timer + 32'd1 : '0;
            if (r_state == RUN && w_next_state == DUMP) r_fault_lat <= faulted_flag || w_timeout;
            if (r_state != DUMP)  r_issue_cnt <= '0;
            else if (w_req_fire)  r_issue_cnt <= r_issue_cnt + 1'b1;
            if (r_state != DUMP)  r_ret_cnt <= '0;
            else if (w_dump_fire) r_ret_cnt <= r_ret_cnt + 1'b1;
            if (w_dump_fire) r_last_word <= resp_data;
            if (r_state != PATCH) r_patch_sent <= 1'b0;
            else if (w_req_fire)  r_patch_sent <= 1'b1;
            // The mailbox of the next run carries this run's final word.
            if (r_state == PATCH && w_next_state != PATCH) begin
                r_run_index <= r_run_index + 1'b1;
                r_mbox_dat  <= r_last_word;
            end
            if (w_resp_fire && !w_resp_expected) r_proto_err <= 1'b1;
        end
    end

    gecko_credit_counter #(
        .MAX_COUNT (MAX_OUTSTANDING)
    ) u_credit (
        .clk     (clk),
        .rst_n   (rst),
        .i_inc   (w_req_fire && (r_state == DUMP)),
        .i_dec   (w_dump_fire),
        .o_count (w_outstanding),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!r_proto_err);
            assert (w_outstanding <= OUT_W'(MAX_OUTSTANDING));
        end
    end

    assign core_rst   = r_core_rst;
    assign dump_data  = resp_data;
    assign dump_last  = dump_valid && w_last_ret;
    assign dump_fault = dump_valid && r_fault_lat;
    assign run_index  = r_run_index;
    assign busy       = (r_state != IDLE) && (r_state != DONE);
    assign done       = (r_state == DONE);

endmodule

// File: tb/tb_gecko_run_supervisor.sv
// Directed bench for gecko_run_supervisor: core model, latency-configurable slave, stream monitors.
module tb_gecko_run_supervisor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        finished_flag = 1'b0, faulted_flag = 1'b0;
    logic        req_ready = 1'b0, resp_valid = 1'b0, resp_id = 1'b0, dump_ready = 1'b0;
    logic [31:0] resp_data = '0;

    logic        core_rst, req_valid, req_read_enable, req_id, resp_ready;
    logic [3:0]  req_write_enable;
    logic [31:0] req_addr, req_data, dump_data;
    logic        dump_valid, dump_last, dump_fault, busy, done;
    logic [1:0]  run_index;

    gecko_run_supervisor #(
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .core_rst         (core_rst),
        .finished_flag    (finished_flag),
        .faulted_flag     (faulted_flag),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_read_enable  (req_read_enable),
        .req_write_enable (req_write_enable),
        .req_addr         (req_addr),
        .req_data         (req_data),
        .req_id           (req_id),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_data        (resp_data),
        .resp_id          (resp_id),
        .dump_valid       (dump_valid),
        .dump_ready       (dump_ready),
        .dump_data        (dump_data),
        .dump_last        (dump_last),
        .dump_fault       (dump_fault),
        .run_index        (run_index),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] dat;
        logic        id;
    } rsp_t;

    rsp_t        q[$];
    int          hold_q[$], run_q[$];
    logic [31:0] addr_q[$], word_q[$], mbox_q[$];
    logic        last_q[$], fault_q[$];

    int   n_cmp = 0, n_fail = 0;
    int   lat = 1, core_mode = 0;
    bit   rr_toggle = 0, dr_toggle = 0;
    int   cyc = 0, rd_cnt = 0, ccnt = 0, hlen = 0, rlen = 0;
    int   out_cnt = 0, max_out = 0, stab_err = 0, fmt_err = 0;
    bit   seen_req = 0, prev_pend = 0;
    logic [69:0] prev_pay = '0;
    rsp_t e;

    // Slave, core model and monitors: inputs change at negedge, handshakes are read 1ns later.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            q.delete(); hold_q.delete(); run_q.delete(); addr_q.delete();
            word_q.delete(); mbox_q.delete(); last_q.delete(); fault_q.delete();
            rd_cnt = 0; ccnt = 0; hlen = 0; rlen = 0; seen_req = 0; prev_pend = 0;
            out_cnt = 0; max_out = 0; stab_err = 0; fmt_err = 0;
            req_ready = 0; dump_ready = 0; resp_valid = 0; resp_data = '0; resp_id = 0;
            finished_flag = 0; faulted_flag = 0;
        end else begin
            req_ready  = rr_toggle ? cyc[0] : 1'b1;
            dump_ready = dr_toggle ? !cyc[0] : 1'b1;
            if (q.size() > 0 && q[0].due <= cyc) begin
                resp_valid = 1'b1; resp_data = q[0].dat; resp_id = q[0].id;
            end else begin
                resp_valid = 1'b0; resp_data = '0; resp_id = 1'b0;
            end
            if (core_rst) begin
                ccnt = 0; finished_flag = 0; faulted_flag = 0;
            end else begin
                ccnt++;
                if (ccnt >= 50 && core_mode != 1) finished_flag = 1'b1;
                if (ccnt >= 50 && core_mode == 2) faulted_flag = 1'b1;
            end
            #1;
            if (busy && core_rst) hlen++;
            else begin
                if (hlen != 0) hold_q.push_back(hlen);
                hlen = 0;
            end
            if (core_rst) begin
                rlen = 0; seen_req = 0;
            end else if (!seen_req) begin
                if (req_valid) begin run_q.push_back(rlen); seen_req = 1; end
                else rlen++;
            end
            if (prev_pend && {req_valid, req_read_enable, req_write_enable, req_addr, req_data} != prev_pay)
                stab_err++;
            prev_pend = req_valid && !req_ready;
            prev_pay  = {req_valid, req_read_enable, req_write_enable, req_addr, req_data};
            if (resp_valid && resp_ready) begin
                if (resp_id == 1'b0) out_cnt--;
                q.delete(0);
            end
            if (req_valid && req_ready) begin
                e.due = cyc + lat;
                e.id  = req_id;
                e.dat = req_read_enable ? 32'hD000_0000 + rd_cnt : 32'hEEEE_EEEE;
                q.push_back(e);
                if (req_read_enable) begin
                    rd_cnt++; out_cnt++;
                    if (out_cnt > max_out) max_out = out_cnt;
                    addr_q.push_back(req_addr);
                    if (req_write_enable != 4'h0 || req_id != 1'b0) fmt_err++;
                end else begin
                    mbox_q.push_back(req_data);
                    if (req_addr != 32'h0 || req_write_enable != 4'hF || req_id != 1'b1) fmt_err++;
                end
            end
            if (dump_valid && dump_ready) begin
                word_q.push_back(dump_data); last_q.push_back(dump_last); fault_q.push_back(dump_fault);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string t);
        chk({t, ":core_rst"},   core_rst,   1);
        chk({t, ":req_valid"},  req_valid,  0);
        chk({t, ":dump_valid"}, dump_valid, 0);
        chk({t, ":busy"},       busy,       0);
        chk({t, ":done"},       done,       0);
        chk({t, ":run_index"},  run_index,  0);
    endtask

    task automatic do_reset();
        @(posedge clk); #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic run_to_done(input string t);
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(posedge clk); #1;
        end
        chk({t, ":done"}, done, 1);
        chk({t, ":run_index_end"}, run_index, 3);
        chk({t, ":core_rst_end"}, core_rst, 1);
    endtask

    task automatic check_runs(input string t, input int nruns, input logic fexp, input int rlen_exp);
        chk({t, ":n_holds"}, hold_q.size(), nruns);
        for (int i = 0; i < hold_q.size(); i++) chk($sformatf("%s:hold%0d", t, i), hold_q[i], 20);
        chk({t, ":n_runs"}, run_q.size(), nruns);
        for (int i = 0; i < run_q.size(); i++) chk($sformatf("%s:runlen%0d", t, i), run_q[i], rlen_exp);
        chk({t, ":n_reads"}, addr_q.size(), 4 * nruns);
        for (int i = 0; i < addr_q.size(); i++) chk($sformatf("%s:addr%0d", t, i), addr_q[i], 4 * (i % 4));
        chk({t, ":n_words"}, word_q.size(), 4 * nruns);
        for (int i = 0; i < word_q.size(); i++) begin
            chk($sformatf("%s:word%0d", t, i),  word_q[i],  32'hD000_0000 + i);
            chk($sformatf("%s:last%0d", t, i),  last_q[i],  (i % 4) == 3);
            chk($sformatf("%s:fault%0d", t, i), fault_q[i], fexp);
        end
        chk({t, ":n_mbox"}, mbox_q.size(), nruns);
        for (int i = 0; i < mbox_q.size(); i++)
            chk($sformatf("%s:mbox%0d", t, i), mbox_q[i], (i == 0) ? 32'h0 : 32'hD000_0000 + 4 * i - 1);
        chk({t, ":req_format"}, fmt_err, 0);
        chk({t, ":payload_stable"}, stab_err, 0);
    endtask

    initial begin
        #2 rst = 1'b0;
        #1 chk_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;

        run_to_done("basic");
        check_runs("basic", 3, 1'b0, 50);

        lat = 5; rr_toggle = 1; dr_toggle = 1;
        do_reset();
        run_to_done("backpressure");
        check_runs("backpressure", 3, 1'b0, 50);
        chk("backpressure:max_outstanding", max_out, 2);

        lat = 1; rr_toggle = 0; dr_toggle = 0; core_mode = 1;
        do_reset();
        run_to_done("timeout");
        check_runs("timeout", 3, 1'b1, 100);

        core_mode = 2;
        do_reset();
        run_to_done("both_flags");
        check_runs("both_flags", 3, 1'b1, 50);

        core_mode = 0; lat = 5;
        do_reset();
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        for (int i = 0; i < 2000 && !(run_index == 2'd1 && rd_cnt == 5); i++) begin
            @(posedge clk); #2;
        end
        chk("midreset:run_index_pre", run_index, 1);
        chk("midreset:outstanding_pre", out_cnt, 1);
        rst = 1'b0;
        #1 chk_reset_outputs("midreset");
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        run_to_done("after_midreset");
        check_runs("after_midreset", 3, 1'b0, 50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
